// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: fetch FSM encoding,
// the opcode/func values the control decoder keys on, and the default boot PC.
package mips_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  localparam logic [5:0] OP_BEQ  = 6'h4;
  localparam logic [5:0] OP_BNE  = 6'h5;
  localparam logic [5:0] OP_J    = 6'h2;
  localparam logic [5:0] OP_JAL  = 6'h3;
  localparam logic [5:0] FUNC_JR = 6'h8;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC select: jr, then jump, then taken branch, else PC+4.
// Also flags a jr whose register target is not word aligned.
module mips_next_pc
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ir,
  input  logic            branch,
  input  logic            bne,
  input  logic            jump,
  input  logic            jr,
  input  logic            zero,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pcp4,
  output logic [XLEN-1:0] next_pc,
  output logic            align_err
);

  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] jr_target;

  assign pcp4          = pc + 32'd4;
  assign branch_taken  = (branch && zero) || (bne && !zero);
  assign branch_target = pcp4 + {imm_ext[XLEN-3:0], 2'b00};
  assign jump_target   = {pcp4[31:28], ir[25:0], 2'b00};
  assign jr_target     = {rs_data[31:2], 2'b00};
  assign align_err     = jr && (rs_data[1:0] != 2'b00);

  // The decoder raises jump alongside jr, so jr must be tested first.
  always_comb begin
    next_pc = pcp4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch / next-PC stage: req/ack fetch into the IR, then hold
// until the datapath commits and the next PC is chosen from decoder outputs.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  output logic [XLEN-1:0] instr_out,
  output logic [5:0]      op_out,
  output logic [5:0]      func_out,
  output logic            instr_valid_out,
  input  logic            branch_in,
  input  logic            bne_in,
  input  logic            jump_in,
  input  logic            jr_in,
  input  logic            jal_in,
  input  logic            zero_in,
  input  logic [XLEN-1:0] imm_ext_in,
  input  logic [XLEN-1:0] rs_data_in,
  input  logic            commit_in,
  input  logic            stall_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] link_out,
  output logic            align_err_out,
  output logic [XLEN-1:0] retired_out
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] ir_reg, ir_next;
  logic            align_err_reg, align_err_next;
  logic [XLEN-1:0] retired_reg, retired_next;

  logic [XLEN-1:0] pcp4;
  logic [XLEN-1:0] sel_pc;
  logic            jr_misaligned;
  logic            commit_go;

  mips_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc        (pc_reg),
    .ir        (ir_reg),
    .branch    (branch_in),
    .bne       (bne_in),
    .jump      (jump_in),
    .jr        (jr_in),
    .zero      (zero_in),
    .imm_ext   (imm_ext_in),
    .rs_data   (rs_data_in),
    .pcp4      (pcp4),
    .next_pc   (sel_pc),
    .align_err (jr_misaligned)
  );

  assign commit_go = commit_in && !stall_in;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    align_err_next = align_err_reg;
    retired_next   = retired_reg;
    case (state_reg)
      FETCH: begin
        if (imem_ack_in) begin
          ir_next    = imem_rdata_in;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // Acks here are spurious and deliberately ignored.
        if (commit_go) begin
          pc_next        = sel_pc;
          retired_next   = retired_reg + 32'd1;
          align_err_next = align_err_reg | jr_misaligned;
          state_next     = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      ir_reg        <= '0;
      align_err_reg <= 1'b0;
      retired_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      align_err_reg <= align_err_next;
      retired_reg   <= retired_next;
    end
  end

  // Request is masked while reset is high so nothing is issued that cycle.
  assign imem_req_out    = (state_reg == FETCH) && !reset;
  assign imem_addr_out   = pc_reg;
  assign instr_out       = ir_reg;
  assign op_out          = ir_reg[31:26];
  assign func_out        = ir_reg[5:0];
  assign instr_valid_out = (state_reg == EXEC);
  assign pc_out          = pc_reg;
  assign link_out        = pcp4;
  assign align_err_out   = align_err_reg;
  assign retired_out     = retired_reg;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: stimulus queues expected fetches and
// IR contents, a negedge monitor pops and compares when the DUT presents them.
module tb_mips_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] retired;
    logic        align;
  } fetch_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_rdata_in;
  logic [31:0] instr_out;
  logic [5:0]  op_out;
  logic [5:0]  func_out;
  logic        instr_valid_out;
  logic        branch_in, bne_in, jump_in, jr_in, jal_in, zero_in;
  logic [31:0] imm_ext_in;
  logic [31:0] rs_data_in;
  logic        commit_in;
  logic        stall_in;
  logic [31:0] pc_out;
  logic [31:0] link_out;
  logic        align_err_out;
  logic [31:0] retired_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = 0;
  logic        exp_align = 0;
  logic        prev_valid = 0;
  fetch_exp_t  exp_fetch[$];
  logic [31:0] exp_ir[$];

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in), .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out), .op_out(op_out), .func_out(func_out),
    .instr_valid_out(instr_valid_out),
    .branch_in(branch_in), .bne_in(bne_in), .jump_in(jump_in),
    .jr_in(jr_in), .jal_in(jal_in), .zero_in(zero_in),
    .imm_ext_in(imm_ext_in), .rs_data_in(rs_data_in),
    .commit_in(commit_in), .stall_in(stall_in),
    .pc_out(pc_out), .link_out(link_out), .align_err_out(align_err_out),
    .retired_out(retired_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: accepted fetches and newly valid instructions.
  always @(negedge clk) begin
    if (!reset && imem_req_out && imem_ack_in) begin
      if (exp_fetch.size() == 0) begin
        check("fetch_unexpected", imem_addr_out, 32'hxxxx_xxxx);
      end else begin
        fetch_exp_t e;
        e = exp_fetch.pop_front();
        check("fetch_addr", imem_addr_out, e.addr);
        check("fetch_retired", retired_out, e.retired);
        check("fetch_align", {31'b0, align_err_out}, {31'b0, e.align});
        $display("fetch addr=%h retired=%0d align_err=%0b", imem_addr_out, retired_out, align_err_out);
      end
    end
    if (instr_valid_out && !prev_valid) begin
      if (exp_ir.size() == 0) begin
        check("ir_unexpected", instr_out, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] w;
        w = exp_ir.pop_front();
        check("ir_value", instr_out, w);
        check("ir_op", {26'b0, op_out}, {26'b0, w[31:26]});
        check("ir_func", {26'b0, func_out}, {26'b0, w[5:0]});
        $display("instr ir=%h op=%h func=%h", instr_out, op_out, func_out);
      end
    end
    prev_valid <= instr_valid_out;
  end

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] instr, input int waits);
    fetch_exp_t e;
    int n;
    e.addr = addr; e.retired = exp_ret; e.align = exp_align;
    exp_fetch.push_back(e);
    exp_ir.push_back(instr);
    n = 0;
    while (!imem_req_out && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("req_seen", {31'b0, imem_req_out}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("req_hold", {31'b0, imem_req_out}, 32'd1);
      check("addr_hold", imem_addr_out, addr);
      @(posedge clk); #1;
    end
    imem_ack_in = 1'b1;
    imem_rdata_in = instr;
    @(posedge clk); #1;
    imem_ack_in = 1'b0;
    imem_rdata_in = 32'hDEAD_BEEF;
    check("valid_after_ack", {31'b0, instr_valid_out}, 32'd1);
    check("req_low_exec", {31'b0, imem_req_out}, 32'd0);
  endtask

  task automatic do_commit(input logic br, input logic bn, input logic jp, input logic j_r,
                           input logic jl, input logic z, input logic [31:0] imm,
                           input logic [31:0] rs);
    branch_in = br; bne_in = bn; jump_in = jp; jr_in = j_r; jal_in = jl; zero_in = z;
    imm_ext_in = imm; rs_data_in = rs;
    commit_in = 1'b1; stall_in = 1'b0;
    @(posedge clk); #1;
    commit_in = 1'b0;
    branch_in = 0; bne_in = 0; jump_in = 0; jr_in = 0; jal_in = 0; zero_in = 0;
    imm_ext_in = 0; rs_data_in = 0;
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; imem_ack_in = 0; imem_rdata_in = 0;
    branch_in = 0; bne_in = 0; jump_in = 0; jr_in = 0; jal_in = 0; zero_in = 0;
    imm_ext_in = 0; rs_data_in = 0; commit_in = 0; stall_in = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req_out}, 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'b0, instr_valid_out}, 32'd0);
    check("rst_retired", retired_out, 32'h0);
    check("rst_align", {31'b0, align_err_out}, 32'd0);
    check("rst_link", link_out, 32'h4);
    @(posedge clk); #1;
    reset = 0;

    do_fetch(32'h0000_0000, 32'h2008_0005, 3);             // addi
    do_commit(0, 0, 0, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0004, 32'h0800_0040, 0);             // j 0x100
    do_commit(0, 0, 1, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0100, 32'h1000_FFFE, 1);             // beq taken
    do_commit(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 0);
    do_fetch(32'h0000_00FC, 32'h0800_0040, 0);             // back to 0x100
    do_commit(0, 0, 1, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0100, 32'h1000_FFFE, 0);             // beq not taken
    do_commit(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 0);
    do_fetch(32'h0000_0104, 32'h0800_0080, 0);             // j 0x200
    do_commit(0, 0, 1, 0, 0, 0, 0, 0);
    do_fetch(32'h0000_0200, 32'h1400_0003, 0);             // bne taken
    do_commit(0, 1, 0, 0, 0, 0, 32'h3, 0);
    do_fetch(32'h0000_0210, 32'h0100_0008, 0);             // jr aligned
    do_commit(0, 0, 1, 1, 0, 0, 0, 32'h9000_0000);
    do_fetch(32'h9000_0000, 32'h0C00_0010, 0);             // jal
    check("jal_link", link_out, 32'h9000_0004);
    do_commit(0, 0, 1, 0, 1, 0, 0, 0);
    do_fetch(32'h9000_0040, 32'h0100_0008, 0);             // jr misaligned
    do_commit(0, 0, 1, 1, 0, 0, 0, 32'h0000_1236);
    exp_align = 1;
    do_fetch(32'h0000_1234, 32'h2008_0005, 0);

    // Stalled commits must not advance anything.
    commit_in = 1; stall_in = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_pc", pc_out, 32'h0000_1234);
      check("stall_retired", retired_out, exp_ret);
      check("stall_valid", {31'b0, instr_valid_out}, 32'd1);
    end
    stall_in = 0; commit_in = 0;
    do_commit(1, 1, 0, 0, 0, 1, 32'h1, 0);                  // beq+bne, zero=1 -> taken
    check("align_sticky", {31'b0, align_err_out}, 32'd1);
    check("both_branch_pc", pc_out, 32'h0000_123C);

    // Reset mid-FETCH with an ack in the same cycle.
    @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req_out}, 32'd1);
    @(posedge clk); #1;
    imem_ack_in = 1; imem_rdata_in = 32'h1234_5678; reset = 1;
    @(negedge clk);
    check("midrst_req", {31'b0, imem_req_out}, 32'd0);
    @(posedge clk); #1;
    reset = 0; imem_ack_in = 0;
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_ir", instr_out, 32'h0);
    check("midrst_align", {31'b0, align_err_out}, 32'd0);
    check("midrst_retired", retired_out, 32'h0);
    check("midrst_valid", {31'b0, instr_valid_out}, 32'd0);
    exp_ret = 0; exp_align = 0;

    do_fetch(32'h0000_0000, 32'h2008_0005, 0);
    imem_ack_in = 1; imem_rdata_in = 32'hFFFF_FFFF;        // spurious ack in EXEC
    @(posedge clk); #1;
    imem_ack_in = 0;
    check("spurious_ir", instr_out, 32'h2008_0005);
    check("spurious_valid", {31'b0, instr_valid_out}, 32'd1);

    @(negedge clk); @(posedge clk); #1;
    check("fetch_queue_empty", exp_fetch.size(), 32'd0);
    check("ir_queue_empty", exp_ir.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
